// File: rtl/vlc_pkg.sv
// Shared types and line levels for the VLC serial link (tx serializer and rx accumulator).
// Define VLC_TX_PARITY_EN to include the PARITY state.
package vlc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef VLC_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_GAP    = 3'd4
    } vlc_tx_state_e;

    localparam logic START_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/vlc_tx_serializer_if.sv
// Word handshake in, serial line out, between the payload logic and the LED modulator.
interface vlc_tx_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             tx_bit;
    logic             tx_en;
    logic             word_done;

    modport master (output in_data, in_valid, input in_ready, tx_bit, tx_en, word_done);
    modport slave  (input in_data, in_valid, output in_ready, tx_bit, tx_en, word_done);
endinterface

// File: rtl/vlc_bit_timer.sv
// Bit-period counter 0..CLKS_PER_BIT-1; shared by the tx serializer and the rx sampler.
module vlc_bit_timer
    import vlc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic bit_tick_o,
    output logic last_next_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign bit_tick_o  = (cnt_q == LAST);
    // Look-ahead lets the owner register a pulse that lands on the final cycle of a bit.
    assign last_next_o = (cnt_d == LAST);

endmodule

// File: rtl/vlc_tx_serializer.sv
// Frames a parallel word as start + data (+ parity with VLC_TX_PARITY_EN) + idle gap on tx_bit.
// All line outputs are registered from the next-state values so they move on bit boundaries.
module vlc_tx_serializer
    import vlc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 2,
    parameter int LSB_FIRST    = 0
) (
    input logic                clk,
    input logic                rst,
    vlc_tx_serializer_if.slave tx_if
);

    localparam int IDX_MAX = (WIDTH > GAP_BITS) ? WIDTH : GAP_BITS;
    localparam int IDX_W   = clog2(IDX_MAX);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_GAP  = IDX_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    vlc_tx_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             tx_bit_q, tx_bit_d;
    logic             tx_en_q, tx_en_d;
    logic             done_q, done_d;
    logic             bit_tick, last_next, in_ready, accept;
`ifdef VLC_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign in_ready = (state_q == ST_IDLE) && rst;
    assign accept   = tx_if.in_valid && in_ready;

    vlc_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (state_q == ST_IDLE),
        .bit_tick_o  (bit_tick),
        .last_next_o (last_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sh_q     <= '0;
            tx_bit_q <= IDLE_LEVEL;
            tx_en_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef VLC_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            tx_bit_q <= tx_bit_d;
            tx_en_q  <= tx_en_d;
            done_q   <= done_d;
`ifdef VLC_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
`ifdef VLC_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_START;
                idx_d   = '0;
                sh_d    = tx_if.in_data;
`ifdef VLC_TX_PARITY_EN
                par_d   = ^tx_if.in_data;
`endif
            end
            ST_START: if (bit_tick) begin
                state_d = ST_DATA;
                idx_d   = '0;
            end
            ST_DATA: if (bit_tick) begin
                if (idx_q == LAST_DATA) begin
                    idx_d = '0;
`ifdef VLC_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                    sh_d  = (LSB_FIRST != 0) ? (sh_q >> 1) : (sh_q << 1);
                end
            end
`ifdef VLC_TX_PARITY_EN
            ST_PARITY: if (bit_tick) state_d = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
`endif
            ST_GAP: if (bit_tick) begin
                if (idx_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_bit_d = IDLE_LEVEL;
        tx_en_d  = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            ST_START: begin
                tx_bit_d = START_LEVEL;
                tx_en_d  = 1'b1;
            end
            ST_DATA: begin
                tx_bit_d = (LSB_FIRST != 0) ? sh_d[0] : sh_d[WIDTH-1];
                tx_en_d  = 1'b1;
`ifndef VLC_TX_PARITY_EN
                done_d   = (idx_d == LAST_DATA) && last_next;
`endif
            end
`ifdef VLC_TX_PARITY_EN
            ST_PARITY: begin
                tx_bit_d = par_q;
                tx_en_d  = 1'b1;
                done_d   = last_next;
            end
`endif
            default: ;
        endcase
    end

    assign tx_if.in_ready  = in_ready;
    assign tx_if.tx_bit    = tx_bit_q;
    assign tx_if.tx_en     = tx_en_q;
    assign tx_if.word_done = done_q;

endmodule

// File: tb/tb_vlc_tx_serializer.sv
// Directed bench: three serializer configurations (MSB/1clk/gap2, LSB/4clk/gap2, MSB/1clk/gap0).
module tb_vlc_tx_serializer;

`ifdef VLC_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_valid = 1'b0;
    logic [7:0] d_data = 8'h00;
    int         sel = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    logic       m_bit, m_en, m_done, m_rdy;

    always #5 clk = ~clk;

    vlc_tx_serializer_if #(.WIDTH(8)) ifa ();
    vlc_tx_serializer_if #(.WIDTH(8)) ifb ();
    vlc_tx_serializer_if #(.WIDTH(8)) ifc ();

    assign ifa.in_valid = d_valid && (sel == 0);
    assign ifb.in_valid = d_valid && (sel == 1);
    assign ifc.in_valid = d_valid && (sel == 2);
    assign ifa.in_data  = d_data;
    assign ifb.in_data  = d_data;
    assign ifc.in_data  = d_data;

    vlc_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .GAP_BITS(2), .LSB_FIRST(0))
        dut_a (.clk(clk), .rst(rst), .tx_if(ifa));
    vlc_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .GAP_BITS(2), .LSB_FIRST(1))
        dut_b (.clk(clk), .rst(rst), .tx_if(ifb));
    vlc_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .GAP_BITS(0), .LSB_FIRST(0))
        dut_c (.clk(clk), .rst(rst), .tx_if(ifc));

    always_comb begin
        m_bit = ifa.tx_bit; m_en = ifa.tx_en; m_done = ifa.word_done; m_rdy = ifa.in_ready;
        if (sel == 1) begin
            m_bit = ifb.tx_bit; m_en = ifb.tx_en; m_done = ifb.word_done; m_rdy = ifb.in_ready;
        end else if (sel == 2) begin
            m_bit = ifc.tx_bit; m_en = ifc.tx_en; m_done = ifc.word_done; m_rdy = ifc.in_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] data, input int i, input int cpb,
                                     input int lsb);
        int b;
        b = i / cpb;
        if (b == 0) return 1'b1;
        if (b <= 8) return (lsb != 0) ? data[b-1] : data[8-b];
        if (PAR == 1 && b == 9) return ^data;
        return 1'b0;
    endfunction

    task automatic accept(input logic [7:0] data, input bit keep);
        int n;
        n = 0;
        d_data  = data;
        d_valid = 1'b1;
        while (!m_rdy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept.rdy", 32'(m_rdy), 32'd1);
        @(posedge clk); #1;
        if (!keep) d_valid = 1'b0;
    endtask

    // Called at the sample point just after the accepting edge; returns at the first idle cycle.
    task automatic check_frame(input logic [7:0] data, input int cpb, input int lsb,
                               input int gap, input string tag, output logic [8:0] pat9,
                               output int en_cnt, output int hi_cnt, output logic bit9);
        int frame, last;
        frame  = 1 + 8 + PAR;
        last   = (frame + gap) * cpb;
        pat9   = '0;
        en_cnt = 0;
        hi_cnt = 0;
        bit9   = 1'b0;
        for (int i = 0; i <= last; i++) begin
            chk($sformatf("%s.bit@%0d", tag, i), 32'(m_bit), 32'(exp_bit(data, i, cpb, lsb)));
            chk($sformatf("%s.en@%0d", tag, i), 32'(m_en), 32'((i / cpb) < frame));
            chk($sformatf("%s.done@%0d", tag, i), 32'(m_done), 32'(i == frame * cpb - 1));
            chk($sformatf("%s.rdy@%0d", tag, i), 32'(m_rdy), 32'(i >= last));
            if (i < 9) pat9 = {pat9[7:0], m_bit};
            if (i == 9 * cpb) bit9 = m_bit;
            if (m_en) en_cnt++;
            if (m_bit) hi_cnt++;
            if (i < last) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        logic [8:0] pat;
        int         en_c, hi_c;
        logic       b9;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.bit", 32'(ifa.tx_bit), 32'd0);
        chk("rst.en", 32'(ifa.tx_en), 32'd0);
        chk("rst.done", 32'(ifa.word_done), 32'd0);
        chk("rst.rdy", 32'(ifa.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel.rdy_a", 32'(ifa.in_ready), 32'd1);
        chk("rel.rdy_b", 32'(ifb.in_ready), 32'd1);
        chk("rel.rdy_c", 32'(ifc.in_ready), 32'd1);

        // MSB-first 0xA5 at one clock per bit
        sel = 0;
        accept(8'hA5, 1'b0);
        check_frame(8'hA5, 1, 0, 2, "a5", pat, en_c, hi_c, b9);
        chk("a5.pattern", 32'(pat), 32'(9'b110100101));
        chk("a5.en_cycles", 32'(en_c), 32'(9 + PAR));
`ifdef VLC_TX_PARITY_EN
        chk("a5.parity", 32'(b9), 32'd0);
        accept(8'h07, 1'b0);
        check_frame(8'h07, 1, 0, 2, "p07", pat, en_c, hi_c, b9);
        chk("p07.parity", 32'(b9), 32'd1);
`endif

        // LSB-first 0x01 at four clocks per bit
        sel = 1;
        accept(8'h01, 1'b0);
        check_frame(8'h01, 4, 1, 2, "b01", pat, en_c, hi_c, b9);
        chk("b01.en_cycles", 32'(en_c), 32'(36 + 4 * PAR));
        chk("b01.hi_cycles", 32'(hi_c), 32'(8 + 4 * PAR));

        // in_valid held high: one accept per frame, data change mid-frame ignored
        sel = 0;
        accept(8'h3C, 1'b1);
        d_data = 8'hC3;
        check_frame(8'h3C, 1, 0, 2, "s3c", pat, en_c, hi_c, b9);
        chk("s3c.pattern", 32'(pat), 32'(9'b100111100));
        @(posedge clk); #1;
        d_valid = 1'b0;
        check_frame(8'hC3, 1, 0, 2, "sc3", pat, en_c, hi_c, b9);
        chk("sc3.pattern", 32'(pat), 32'(9'b111000011));

        // GAP_BITS=0: back-to-back frames with one idle cycle between
        sel = 2;
        accept(8'hA5, 1'b1);
        d_data = 8'h5A;
        check_frame(8'hA5, 1, 0, 0, "g0a", pat, en_c, hi_c, b9);
        @(posedge clk); #1;
        d_valid = 1'b0;
        check_frame(8'h5A, 1, 0, 0, "g05", pat, en_c, hi_c, b9);
        chk("g05.pattern", 32'(pat), 32'(9'b101011010));

        // Reset during data bit 3 of 0xFF
        sel = 0;
        accept(8'hFF, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("mid.bit3", 32'(m_bit), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid.bit", 32'(m_bit), 32'd0);
        chk("mid.en", 32'(m_en), 32'd0);
        chk("mid.done", 32'(m_done), 32'd0);
        chk("mid.rdy", 32'(m_rdy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid.rdy_rel", 32'(m_rdy), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mid.nodone@%0d", i), 32'(m_done), 32'd0);
            chk($sformatf("mid.noen@%0d", i), 32'(m_en), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vlc_tx_serializer.md
Name: vlc_tx_serializer

Overview:
- Transmit-side counterpart of the link's serial-to-parallel accumulator.
- Accepts a parallel word over a valid/ready handshake and frames it as an on-off-keyed serial bit stream for the LED driver: one start bit, WIDTH data bits, optional parity bit, then an idle gap.
- Sits between the packet/payload logic and the LED modulator stage.

Parameters:
- WIDTH, 8: data word width in bits; must be >= 2.
- CLKS_PER_BIT, 1: clk cycles each serial bit is held; must be >= 1.
- GAP_BITS, 2: bit periods of forced-low line after each frame; 0 allowed.
- LSB_FIRST, 0: 0 = data sent MSB first; 1 = LSB first.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to transmit; sampled on the accepting edge only.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- tx_bit  output  1  serial line level to the modulator; idle level 0.
- tx_en  output  1  high while a start, data or parity bit is on tx_bit.
- word_done  output  1  single-cycle pulse in the final clk of the last frame bit.

Behaviour:
- Reset (rst low, async): state IDLE, shift register 0, counters 0. Outputs: tx_bit 0, tx_en 0, word_done 0. in_ready is 0 while rst is low and 1 on the first cycle after release.
- States: IDLE, START, DATA, PARITY (macro only), GAP.
- in_ready is high exactly when state == IDLE and rst is high. It is derived combinationally from registered state.
- Accept occurs on the clk edge where in_valid && in_ready. in_data is latched into the shift register and the state goes to START. No combinational path runs from in_valid to in_ready.
- All outputs are registered. tx_bit and tx_en change only at bit-period boundaries.
- START: tx_bit 1, tx_en 1 for CLKS_PER_BIT cycles, then DATA.
- DATA: WIDTH bits, each held CLKS_PER_BIT cycles, in the order set by LSB_FIRST. The bit index counter counts 0..WIDTH-1. After the last bit the state goes to PARITY (macro defined), else to GAP, or to IDLE if GAP_BITS == 0.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. With CLKS_PER_BIT == 1 it is constant 0 and each bit lasts one cycle.
- word_done asserts during the last clk of the last frame bit (last data bit, or the parity bit when enabled).
- GAP: tx_bit 0, tx_en 0, in_ready 0 for GAP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Latency: on an accept at edge k, the start bit appears on tx_bit after edge k. Frame length is (1+WIDTH[+1])*CLKS_PER_BIT cycles.
- Minimum accept-to-accept spacing is (frame + GAP_BITS)*CLKS_PER_BIT + 1 cycles; the +1 is the single IDLE cycle.
- in_valid or in_data changing while not IDLE is ignored; there is no buffering.
- in_valid dropping mid-frame has no effect.
- Reset mid-frame truncates the frame immediately: tx_bit goes to 0 asynchronously and no word_done is produced.

Optional Feature:
- Macro VLC_TX_PARITY_EN.
- Defined: after DATA, a PARITY state sends the even-parity bit (XOR of the latched word) for CLKS_PER_BIT cycles with tx_en 1. word_done moves to the last cycle of the parity bit.
- Undefined: no PARITY state, no parity logic. Frame is 1+WIDTH bits.

Decomposition:
- Package vlc_pkg holds:
  - the tx state enum (IDLE/START/DATA/PARITY/GAP);
  - constants START_LEVEL = 1 and IDLE_LEVEL = 0;
  - a clog2 helper for counter widths.
- The receiver shares START_LEVEL and IDLE_LEVEL from the same package.
- One sub-module, vlc_bit_timer, is natural. It is a CLKS_PER_BIT counter with a clear input and a bit_tick output, and is reused by the receiver for sampling.

Test Plan:
- WIDTH=8, CLKS_PER_BIT=1, GAP_BITS=2, in_data=0xA5 accepted -> tx_bit 1,1,0,1,0,0,1,0,1 on consecutive cycles, tx_en high for 9 cycles, word_done on cycle 9, then 2 cycles of tx_bit 0, then in_ready 1.
- CLKS_PER_BIT=4, LSB_FIRST=1, in_data=0x01 -> start bit 4 cycles high, then data bit0 4 cycles high, then 28 cycles low with tx_en 1; frame totals 36 cycles.
- in_valid held high continuously with in_data 0x3C then 0xC3 -> exactly one accept per frame, spaced 9+2+1 = 12 cycles at CLKS_PER_BIT=1; second frame carries 0xC3.
- VLC_TX_PARITY_EN defined: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame 10 bits; word_done on the parity bit.
- rst pulsed low during data bit 3 of 0xFF -> tx_bit 0 and tx_en 0 immediately, no word_done, in_ready 1 on the first cycle after release.
- GAP_BITS=0 -> in_ready high on the cycle after the last data bit; back-to-back frames separated by exactly 1 idle cycle.
